// File: rtl/pal_cfg_pkg.sv
// Shared types and helpers for the PAL configuration streamer.
// Only the PAL_CFG_CRC_EN build of pal_cfg_streamer uses crc8_step.
package pal_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOW,
      ST_HIGH,
      ST_FINISH
   } cfg_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // AND-plane carries true and complement of every input per product term.
   function automatic int cfg_bits_calc(input int n, input int p, input int m);
      return (2 * n * p) + (p * m);
   endfunction

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return fb ? ({crc[6:0], 1'b0} ^ CRC8_POLY) : {crc[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/pal_cfg_streamer_if.sv
// Word handshake between the bitstream source and the PAL config streamer.
interface pal_cfg_streamer_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/pal_cfg_clkdiv.sv
// Half-period timer for cfg_clk: one-cycle tick every CLK_DIV clocks while enabled.
module pal_cfg_clkdiv #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic res_n,
   input  logic en,
   output logic tick
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt <= RELOAD;
      end else if (!en || (cnt == '0)) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/pal_cfg_streamer.sv
// Serializes parallel bitstream words MSB-first onto the PAL config pins.
// Build option PAL_CFG_CRC_EN adds crc_out, a CRC-8 of the bits clocked into the PAL.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; cfg_en holds the result of the last load
//   ST_FETCH  | word_ready high, cfg_clk low, waiting for the next word
//   ST_LOW    | cfg_data presented, cfg_clk low for CLK_DIV cycles
//   ST_HIGH   | cfg_clk high for CLK_DIV cycles, PAL samples on the rise
//   ST_FINISH | one-cycle done pulse, raise cfg_en
module pal_cfg_streamer
   import pal_cfg_pkg::*;
#(
   parameter int WORD_W   = 8,
   parameter int CFG_BITS = cfg_bits_calc(8, 11, 6),
   parameter int CLK_DIV  = 4
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic                start,
   pal_cfg_streamer_if.slave   word_if,
   output logic                busy,
   output logic                done,
   output logic                cfg_data,
   output logic                cfg_clk,
   output logic                cfg_en
`ifdef PAL_CFG_CRC_EN
   ,
   output logic [7:0]          crc_out
`endif
);
   localparam int CNT_W = $clog2(CFG_BITS + 1);
   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORD_W - 1);

   cfg_state_t        state;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_nxt;
   logic [IDX_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  bit_cnt;
   logic              word_ready_q;
   logic              half_en;
   logic              half_tick;

   assign word_if.word_ready = word_ready_q;
   assign half_en   = (state == ST_LOW) || (state == ST_HIGH);
   assign shreg_nxt = shreg << 1;

   pal_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
      .clk   (clk),
      .res_n (res_n),
      .en    (half_en),
      .tick  (half_tick)
   );

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         bit_idx      <= '0;
         bit_cnt      <= '0;
         word_ready_q <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_data     <= 1'b0;
         cfg_clk      <= 1'b0;
         cfg_en       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_FETCH;
                  bit_cnt      <= '0;
                  cfg_en       <= 1'b0;
                  busy         <= 1'b1;
                  word_ready_q <= 1'b1;
               end
            end
            ST_FETCH: begin
               cfg_clk <= 1'b0;
               if (word_if.word_valid && word_ready_q) begin
                  shreg        <= word_if.word_data;
                  bit_idx      <= IDX_TOP;
                  cfg_data     <= word_if.word_data[WORD_W-1];
                  word_ready_q <= 1'b0;
                  state        <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (half_tick) begin
                  cfg_clk <= 1'b1;
                  state   <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (half_tick) begin
                  cfg_clk <= 1'b0;
                  bit_cnt <= bit_cnt + CNT_ONE;
                  // Leftover LSBs of a partial last word are simply dropped here.
                  if (bit_cnt == CNT_LAST) begin
                     state <= ST_FINISH;
                     done  <= 1'b1;
                  end else if (bit_idx == '0) begin
                     state        <= ST_FETCH;
                     word_ready_q <= 1'b1;
                  end else begin
                     shreg    <= shreg_nxt;
                     cfg_data <= shreg_nxt[WORD_W-1];
                     bit_idx  <= bit_idx - 1'b1;
                     state    <= ST_LOW;
                  end
               end
            end
            ST_FINISH: begin
               busy   <= 1'b0;
               cfg_en <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef PAL_CFG_CRC_EN
   // The LOW->HIGH step is the same edge on which cfg_clk rises at the PAL.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         crc_out <= 8'h00;
      end else if ((state == ST_IDLE) && start) begin
         crc_out <= 8'h00;
      end else if ((state == ST_LOW) && half_tick) begin
         crc_out <= crc8_step(crc_out, cfg_data);
      end
   end
`endif

endmodule

// File: tb/tb_pal_cfg_streamer.sv
// Scoreboard bench: a 242-bit/CLK_DIV=1 streamer and an 8-bit/CLK_DIV=4 streamer.
module tb_pal_cfg_streamer;
   localparam int FAST_BITS = 242;
   localparam int SLOW_BITS = 8;
   localparam int SLOW_DIV  = 4;

   logic clk = 1'b0;
   logic res_n = 1'b0;
   logic start_f = 1'b0;
   logic start_s = 1'b0;
   logic busy_f, done_f, cfg_data_f, cfg_clk_f, cfg_en_f;
   logic busy_s, done_s, cfg_data_s, cfg_clk_s, cfg_en_s;
`ifdef PAL_CFG_CRC_EN
   logic [7:0] crc_f, crc_s;
`endif

   pal_cfg_streamer_if #(.WORD_W(8)) if_f ();
   pal_cfg_streamer_if #(.WORD_W(8)) if_s ();

   pal_cfg_streamer #(.WORD_W(8), .CFG_BITS(FAST_BITS), .CLK_DIV(1)) u_dut_fast (
      .clk      (clk),
      .res_n    (res_n),
      .start    (start_f),
      .word_if  (if_f),
      .busy     (busy_f),
      .done     (done_f),
      .cfg_data (cfg_data_f),
      .cfg_clk  (cfg_clk_f),
      .cfg_en   (cfg_en_f)
`ifdef PAL_CFG_CRC_EN
      ,
      .crc_out  (crc_f)
`endif
   );

   pal_cfg_streamer #(.WORD_W(8), .CFG_BITS(SLOW_BITS), .CLK_DIV(SLOW_DIV)) u_dut_slow (
      .clk      (clk),
      .res_n    (res_n),
      .start    (start_s),
      .word_if  (if_s),
      .busy     (busy_s),
      .done     (done_s),
      .cfg_data (cfg_data_s),
      .cfg_clk  (cfg_clk_s),
      .cfg_en   (cfg_en_s)
`ifdef PAL_CFG_CRC_EN
      ,
      .crc_out  (crc_s)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] crc_model(input logic [7:0] c, input bit b);
      if (c[7] ^ b) return {c[6:0], 1'b0} ^ 8'h07;
      return {c[6:0], 1'b0};
   endfunction

   // fast-instance scoreboard and model state
   bit         q_f[$];
   int         pushed_f, edges_f, done_cnt_f;
   bit         last_bit_f;
   bit         abort_f = 1'b0;
   logic [7:0] crc_exp_f;
   logic [1:0] tail_f;
   bit         prev_clk_f = 1'b0;

   // slow-instance scoreboard and timing trackers
   bit         q_s[$];
   int         edges_s, low_run, high_run, stable_s;
   logic [7:0] crc_exp_s;
   bit         prev_clk_s = 1'b0;
   logic       prev_data_s = 1'b0;

   always @(negedge clk) begin
      if (!res_n) begin
         prev_clk_f = 1'b0;
      end else begin
         if (cfg_clk_f && !prev_clk_f) begin
            edges_f++;
            tail_f = {tail_f[0], cfg_data_f};
            if (q_f.size() == 0) chk("extra_edge_f", edges_f, pushed_f);
            else chk("bit_f", cfg_data_f, q_f.pop_front());
         end
         if (done_f) done_cnt_f++;
         prev_clk_f = cfg_clk_f;
      end
   end

   always @(negedge clk) begin
      if (!res_n) begin
         prev_clk_s = 1'b0;
         low_run = 0;
         high_run = 0;
         stable_s = 0;
      end else begin
         if (cfg_data_s != prev_data_s) stable_s = 1;
         else stable_s++;
         prev_data_s = cfg_data_s;
         if (cfg_clk_s && !prev_clk_s) begin
            edges_s++;
            chk("slow_low_len", low_run >= SLOW_DIV, 1);
            chk("slow_setup", stable_s > SLOW_DIV, 1);
            if (q_s.size() == 0) chk("extra_edge_s", edges_s, SLOW_BITS);
            else chk("bit_s", cfg_data_s, q_s.pop_front());
            high_run = 1;
         end else if (cfg_clk_s) begin
            high_run++;
         end else if (prev_clk_s) begin
            chk("slow_high_len", high_run, SLOW_DIV);
            low_run = 1;
         end else begin
            low_run++;
         end
         prev_clk_s = cfg_clk_s;
      end
   end

   task automatic model_word_f(input logic [7:0] w);
      for (int b = 7; b >= 0; b--) begin
         if (pushed_f < FAST_BITS) begin
            q_f.push_back(w[b]);
            crc_exp_f  = crc_model(crc_exp_f, w[b]);
            last_bit_f = w[b];
            pushed_f++;
         end
      end
   endtask

   task automatic push_f(input logic [7:0] w, input int stall);
      int n;
      n = 0;
      if (stall > 0) begin
         while (!if_f.word_ready && !abort_f && n < 400) begin
            @(negedge clk);
            n++;
         end
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_clk_low", cfg_clk_f, 0);
         end
      end else begin
         @(negedge clk);
      end
      if_f.word_data  = w;
      if_f.word_valid = 1'b1;
      n = 0;
      while (!if_f.word_ready && !abort_f && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (abort_f) begin
         if_f.word_valid = 1'b0;
         return;
      end
      chk("ready_wait", n < 400, 1);
      model_word_f(w);
      @(negedge clk);
      if_f.word_valid = 1'b0;
      chk("ready_drop", if_f.word_ready, 0);
   endtask

   task automatic feed_f(input int mode, input int stall_idx, input int stall_len);
      logic [7:0] w;
      for (int i = 0; i < 31; i++) begin
         if (abort_f) break;
         case (mode)
            0:       w = 8'hA5;
            1:       w = 8'(i * 37 + 11);
            default: w = 8'($urandom);
         endcase
         push_f(w, (i == stall_idx) ? stall_len : 0);
      end
   endtask

   task automatic start_load_f();
      q_f.delete();
      pushed_f   = 0;
      edges_f    = 0;
      done_cnt_f = 0;
      crc_exp_f  = 8'h00;
      @(negedge clk);
      start_f = 1'b1;
      @(negedge clk);
      start_f = 1'b0;
   endtask

   task automatic wait_done_f();
      int n;
      n = 0;
      while (!done_f && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done_f, 1);
      chk("en_low_at_done", cfg_en_f, 0);
      chk("bit_edges", edges_f, FAST_BITS);
`ifdef PAL_CFG_CRC_EN
      chk("crc_f", crc_f, crc_exp_f);
`endif
      @(negedge clk);
      chk("en_after_done", cfg_en_f, 1);
      chk("done_one_cycle", done_f, 0);
      chk("busy_clear", busy_f, 0);
      chk("done_count", done_cnt_f, 1);
      chk("sb_drained", q_f.size(), 0);
      chk("data_hold", cfg_data_f, last_bit_f);
   endtask

   task automatic chk_reset_f();
      chk("rst_ready", if_f.word_ready, 0);
      chk("rst_busy", busy_f, 0);
      chk("rst_done", done_f, 0);
      chk("rst_data", cfg_data_f, 0);
      chk("rst_clk", cfg_clk_f, 0);
      chk("rst_en", cfg_en_f, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [7:0] slow_words [2];
      slow_words[0] = 8'h01;
      slow_words[1] = 8'hC3;
      if_f.word_data = '0;
      if_f.word_valid = 1'b0;
      if_s.word_data = '0;
      if_s.word_valid = 1'b0;
      tail_f = 2'b00;

      repeat (3) @(negedge clk);
      chk_reset_f();
      chk("rst_busy_s", busy_s, 0);
      chk("rst_en_s", cfg_en_s, 0);
`ifdef PAL_CFG_CRC_EN
      chk("rst_crc", crc_f, 8'h00);
`endif
      res_n = 1'b1;

      // full load of constant 0xA5 words
      start_load_f();
      feed_f(0, -1, 0);
      wait_done_f();
      chk("tail_bits", tail_f, 2'b10);

      // source stalls before word 5
      start_load_f();
      feed_f(1, 5, 20);
      wait_done_f();

      // asynchronous reset after 100 bits, then a clean reload
      start_load_f();
      fork
         feed_f(2, -1, 0);
         begin
            n = 0;
            while (edges_f < 100 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            chk("reach_100", edges_f, 100);
            #2;
            res_n = 1'b0;
            #1;
            chk_reset_f();
            abort_f = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      q_f.delete();
      abort_f = 1'b0;
      if_f.word_valid = 1'b0;
      res_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy_f, 0);
      start_load_f();
      feed_f(2, -1, 0);
      wait_done_f();

      // start pulsed mid-load must be ignored
      start_load_f();
      fork
         feed_f(1, -1, 0);
         begin
            n = 0;
            while (edges_f < 50 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            start_f = 1'b1;
            @(negedge clk);
            start_f = 1'b0;
         end
      join
      wait_done_f();
      repeat (10) @(negedge clk);
      chk("no_restart_ready", if_f.word_ready, 0);
      chk("no_restart_busy", busy_f, 0);

      // CLK_DIV=4, single-word loads
      for (int j = 0; j < 2; j++) begin
         q_s.delete();
         edges_s = 0;
         crc_exp_s = 8'h00;
         @(negedge clk);
         start_s = 1'b1;
         @(negedge clk);
         start_s = 1'b0;
         if_s.word_data = slow_words[j];
         if_s.word_valid = 1'b1;
         n = 0;
         while (!if_s.word_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("slow_ready_wait", n < 100, 1);
         for (int b = 7; b >= 0; b--) begin
            q_s.push_back(slow_words[j][b]);
            crc_exp_s = crc_model(crc_exp_s, slow_words[j][b]);
         end
         @(negedge clk);
         if_s.word_valid = 1'b0;
         n = 0;
         while (!done_s && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("slow_done", done_s, 1);
         chk("slow_edges", edges_s, SLOW_BITS);
`ifdef PAL_CFG_CRC_EN
         chk("crc_s", crc_s, crc_exp_s);
`endif
         @(negedge clk);
         chk("slow_en", cfg_en_s, 1);
         chk("slow_drained", q_s.size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
